// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the register-bank sequencer.
package regfile_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int IDX_W = $clog2(NREGS);

    typedef logic [IDX_W-1:0] reg_idx_t;

    typedef struct packed {
        logic            valid;
        reg_idx_t        rd;
        logic [XLEN-1:0] data;
    } wr_req_t;

    function automatic logic [NREGS-1:0] onehot(input reg_idx_t idx);
        logic [NREGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/regfile_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; on a conflict the requester not granted last wins.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // last_grant: 0 = requester 0 won last, 1 = requester 1 won last
    logic last_grant;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
        end else if (gnt[0]) begin
            last_grant <= 1'b0;
        end else if (gnt[1]) begin
            last_grant <= 1'b1;
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Write-back arbitration, busy scoreboard and hazard-gated read enables for
// a bank of register instances on shared tri-state A/B buses.
module regfile_arbiter
    import regfile_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rsv_valid,
    input  reg_idx_t         rsv_rd,
    output logic             rsv_ready,
    input  logic             wr0_valid,
    input  reg_idx_t         wr0_rd,
    input  logic [XLEN-1:0]  wr0_data,
    output logic             wr0_ready,
    input  logic             wr1_valid,
    input  reg_idx_t         wr1_rd,
    input  logic [XLEN-1:0]  wr1_data,
    output logic             wr1_ready,
    input  logic             rd_valid,
    input  reg_idx_t         rd_rs1,
    input  reg_idx_t         rd_rs2,
    output logic             rd_ready,
    output logic [NREGS-1:0] enable_a,
    output logic [NREGS-1:0] enable_b,
    output logic [NREGS-1:0] store,
    output logic [XLEN-1:0]  store_data,
    output logic [NREGS-1:0] busy
);

    wr_req_t          wr0_req;
    wr_req_t          wr1_req;
    wr_req_t          win;
    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             grant_any;
    logic             grant_live;
    logic             pend_valid;
    reg_idx_t         pend_rd;
    logic             rsv_accept;
    logic [NREGS-1:0] busy_set;
    logic [NREGS-1:0] busy_clr;
    logic             haz_rs1;
    logic             haz_rs2;

    assign wr0_req = '{valid: wr0_valid, rd: wr0_rd, data: wr0_data};
    assign wr1_req = '{valid: wr1_valid, rd: wr1_rd, data: wr1_data};

    // Readies must stay low while reset is held, so requests are masked here.
    assign req = {wr1_req.valid, wr0_req.valid} & {2{reset_n}};

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .gnt     (gnt)
    );

    assign win        = gnt[1] ? wr1_req : wr0_req;
    assign grant_any  = win.valid && (gnt != 2'b00);
    assign grant_live = grant_any && (win.rd != '0);
    assign wr0_ready  = gnt[0];
    assign wr1_ready  = gnt[1];

    // ---- grant cycle -> issue cycle: one registered store pulse ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            store      <= '0;
            store_data <= '0;
            pend_valid <= 1'b0;
            pend_rd    <= '0;
        end else begin
            store      <= grant_live ? onehot(win.rd) : '0;
            pend_valid <= grant_live;
            if (grant_live) begin
                pend_rd <= win.rd;
            end
            if (grant_any) begin
                store_data <= win.data;
            end
        end
    end

    // Checked against pre-edge busy, so a same-cycle grant cannot free the slot.
    assign rsv_accept = reset_n && rsv_valid && !busy[rsv_rd] &&
                        !(pend_valid && (pend_rd == rsv_rd));
    assign rsv_ready  = rsv_accept;

    assign busy_clr = grant_live ? onehot(win.rd) : '0;
    assign busy_set = (rsv_accept && (rsv_rd != '0)) ? onehot(rsv_rd) : '0;

    // A new reservation outranks a clear from an older write to the same index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~busy_clr) | busy_set;
        end
    end

    assign haz_rs1 = (rd_rs1 != '0) &&
                     (busy[rd_rs1] ||
                      (pend_valid && (pend_rd == rd_rs1)) ||
                      (grant_live && (win.rd == rd_rs1)));
    assign haz_rs2 = (rd_rs2 != '0) &&
                     (busy[rd_rs2] ||
                      (pend_valid && (pend_rd == rd_rs2)) ||
                      (grant_live && (win.rd == rd_rs2)));

    assign rd_ready = reset_n && rd_valid && !haz_rs1 && !haz_rs2;
    assign enable_a = rd_ready ? onehot(rd_rs1) : '0;
    assign enable_b = rd_ready ? onehot(rd_rs2) : '0;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench with a store/read scoreboard and a behavioural register bank.
module tb_regfile_arbiter;

    logic        clk;
    logic        reset_n;
    logic        rsv_valid;
    logic [4:0]  rsv_rd;
    logic        rsv_ready;
    logic        wr0_valid;
    logic [4:0]  wr0_rd;
    logic [31:0] wr0_data;
    logic        wr0_ready;
    logic        wr1_valid;
    logic [4:0]  wr1_rd;
    logic [31:0] wr1_data;
    logic        wr1_ready;
    logic        rd_valid;
    logic [4:0]  rd_rs1;
    logic [4:0]  rd_rs2;
    logic        rd_ready;
    logic [31:0] enable_a;
    logic [31:0] enable_b;
    logic [31:0] store;
    logic [31:0] store_data;
    logic [31:0] busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] st;
        logic [31:0] dat;
    } st_exp_t;

    typedef struct packed {
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] a;
        logic [31:0] b;
    } rd_exp_t;

    st_exp_t st_q[$];
    rd_exp_t rd_q[$];

    logic [31:0] bank [32];
    logic [31:0] bus_a;
    logic [31:0] bus_b;

    regfile_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rsv_valid  (rsv_valid),
        .rsv_rd     (rsv_rd),
        .rsv_ready  (rsv_ready),
        .wr0_valid  (wr0_valid),
        .wr0_rd     (wr0_rd),
        .wr0_data   (wr0_data),
        .wr0_ready  (wr0_ready),
        .wr1_valid  (wr1_valid),
        .wr1_rd     (wr1_rd),
        .wr1_data   (wr1_data),
        .wr1_ready  (wr1_ready),
        .rd_valid   (rd_valid),
        .rd_rs1     (rd_rs1),
        .rd_rs2     (rd_rs2),
        .rd_ready   (rd_ready),
        .enable_a   (enable_a),
        .enable_b   (enable_b),
        .store      (store),
        .store_data (store_data),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register instances: x0 is hardwired zero, the rest capture on store.
    always @(posedge clk) begin
        for (int i = 1; i < 32; i++) begin
            if (store[i]) bank[i] <= store_data;
        end
    end

    always_comb begin
        bus_a = '0;
        bus_b = '0;
        for (int i = 1; i < 32; i++) begin
            if (enable_a[i]) bus_a = bus_a | bank[i];
            if (enable_b[i]) bus_b = bus_b | bank[i];
        end
    end

    always @(negedge clk) begin
        st_exp_t se;
        if (store != '0) begin
            checks++;
            if (st_q.size() == 0) begin
                errors++;
                $display("FAIL store_unexpected: got store=%h data=%h, required no store", store, store_data);
            end else begin
                se = st_q.pop_front();
                if (store !== se.st || store_data !== se.dat) begin
                    errors++;
                    $display("FAIL store: got store=%h data=%h, required store=%h data=%h",
                             store, store_data, se.st, se.dat);
                end
            end
        end
    end

    always @(negedge clk) begin
        rd_exp_t re;
        if (rd_ready) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL read_unexpected: got rd_ready=1 ea=%h eb=%h, required rd_ready=0", enable_a, enable_b);
            end else begin
                re = rd_q.pop_front();
                if (enable_a !== re.ea || enable_b !== re.eb || bus_a !== re.a || bus_b !== re.b) begin
                    errors++;
                    $display("FAIL read: got ea=%h eb=%h A=%h B=%h, required ea=%h eb=%h A=%h B=%h",
                             enable_a, enable_b, bus_a, bus_b, re.ea, re.eb, re.a, re.b);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push_st(input logic [31:0] st, input logic [31:0] dat);
        st_q.push_back('{st: st, dat: dat});
    endtask

    task automatic push_rd(input logic [31:0] ea, input logic [31:0] eb,
                           input logic [31:0] a, input logic [31:0] b);
        rd_q.push_back('{ea: ea, eb: eb, a: a, b: b});
    endtask

    task automatic idle();
        rsv_valid = 1'b0; rsv_rd = '0;
        wr0_valid = 1'b0; wr0_rd = '0; wr0_data = '0;
        wr1_valid = 1'b0; wr1_rd = '0; wr1_data = '0;
        rd_valid  = 1'b0; rd_rs1 = '0; rd_rs2 = '0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        nxt();
        reset_n = 1'b1;
    endtask

    initial begin
        idle();
        reset_n   = 1'b0;
        wr0_valid = 1'b1; wr0_rd = 5'd3;
        rd_valid  = 1'b1; rd_rs1 = 5'd1;
        rsv_valid = 1'b1; rsv_rd = 5'd2;
        @(negedge clk);
        chk("reset_wr0_ready", {31'd0, wr0_ready}, 32'd0);
        chk("reset_rd_ready", {31'd0, rd_ready}, 32'd0);
        chk("reset_rsv_ready", {31'd0, rsv_ready}, 32'd0);
        chk("reset_enable_a", enable_a, 32'd0);
        chk("reset_store", store, 32'd0);
        chk("reset_busy", busy, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle();
        nxt();

        // Single write, then a read that must wait for it to land.
        wr0_valid = 1'b1; wr0_rd = 5'd5; wr0_data = 32'hDEADBEEF;
        push_st(32'h1 << 5, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_wr0_ready", {31'd0, wr0_ready}, 32'd1);
        nxt();
        wr0_valid = 1'b0;
        rd_valid = 1'b1; rd_rs1 = 5'd5; rd_rs2 = 5'd0;
        @(negedge clk);
        chk("t1_read_stall", {31'd0, rd_ready}, 32'd0);
        nxt();
        push_rd(32'h1 << 5, 32'h1, 32'hDEADBEEF, 32'h0);
        @(negedge clk);
        chk("t1_read_ready", {31'd0, rd_ready}, 32'd1);
        nxt();
        idle();

        // Conflicts alternate starting with wr0.
        do_reset();
        wr0_valid = 1'b1; wr0_rd = 5'd3; wr0_data = 32'h33;
        wr1_valid = 1'b1; wr1_rd = 5'd4; wr1_data = 32'h44;
        push_st(32'h1 << 3, 32'h33);
        @(negedge clk);
        chk("t2_c0_wr0", {31'd0, wr0_ready}, 32'd1);
        chk("t2_c0_wr1", {31'd0, wr1_ready}, 32'd0);
        nxt();
        wr0_rd = 5'd10; wr0_data = 32'hAA;
        push_st(32'h1 << 4, 32'h44);
        @(negedge clk);
        chk("t2_c1_wr1", {31'd0, wr1_ready}, 32'd1);
        chk("t2_c1_wr0", {31'd0, wr0_ready}, 32'd0);
        nxt();
        wr1_rd = 5'd11; wr1_data = 32'hBB;
        push_st(32'h1 << 10, 32'hAA);
        @(negedge clk);
        chk("t2_c2_wr0", {31'd0, wr0_ready}, 32'd1);
        chk("t2_c2_wr1", {31'd0, wr1_ready}, 32'd0);
        nxt();
        wr0_valid = 1'b0;
        push_st(32'h1 << 11, 32'hBB);
        @(negedge clk);
        chk("t2_c3_wr1", {31'd0, wr1_ready}, 32'd1);
        nxt();
        idle();
        nxt();

        // Reservation blocks reads and WAW reservations until written back.
        rsv_valid = 1'b1; rsv_rd = 5'd7;
        @(negedge clk);
        chk("t3_rsv_ready", {31'd0, rsv_ready}, 32'd1);
        nxt();
        rsv_valid = 1'b0;
        rd_valid = 1'b1; rd_rs1 = 5'd0; rd_rs2 = 5'd7;
        @(negedge clk);
        chk("t3_busy", busy, 32'h0000_0080);
        chk("t3_stall_busy", {31'd0, rd_ready}, 32'd0);
        nxt();
        rsv_valid = 1'b1; rsv_rd = 5'd7;
        @(negedge clk);
        chk("t4_rsv_waw", {31'd0, rsv_ready}, 32'd0);
        chk("t3_stall_busy2", {31'd0, rd_ready}, 32'd0);
        nxt();
        rsv_valid = 1'b0;
        wr1_valid = 1'b1; wr1_rd = 5'd7; wr1_data = 32'h42;
        push_st(32'h1 << 7, 32'h42);
        @(negedge clk);
        chk("t3_wr1_ready", {31'd0, wr1_ready}, 32'd1);
        chk("t3_stall_grant", {31'd0, rd_ready}, 32'd0);
        nxt();
        wr1_valid = 1'b0;
        @(negedge clk);
        chk("t3_busy_clr", busy, 32'd0);
        chk("t3_stall_pend", {31'd0, rd_ready}, 32'd0);
        nxt();
        push_rd(32'h1, 32'h1 << 7, 32'h0, 32'h42);
        @(negedge clk);
        chk("t3_read_ready", {31'd0, rd_ready}, 32'd1);
        nxt();
        idle();

        // Same-index reservation and grant in one cycle: reservation refused.
        rsv_valid = 1'b1; rsv_rd = 5'd8;
        nxt();
        wr0_valid = 1'b1; wr0_rd = 5'd8; wr0_data = 32'h88;
        push_st(32'h1 << 8, 32'h88);
        @(negedge clk);
        chk("same_rsv_refused", {31'd0, rsv_ready}, 32'd0);
        chk("same_wr0_ready", {31'd0, wr0_ready}, 32'd1);
        nxt();
        idle();
        @(negedge clk);
        chk("same_busy", busy, 32'd0);
        nxt();
        nxt();

        // Write to x0 is accepted but never stored.
        wr0_valid = 1'b1; wr0_rd = 5'd0; wr0_data = 32'hFFFFFFFF;
        @(negedge clk);
        chk("t4_x0_ready", {31'd0, wr0_ready}, 32'd1);
        nxt();
        idle();
        rd_valid = 1'b1; rd_rs1 = 5'd0; rd_rs2 = 5'd0;
        push_rd(32'h1, 32'h1, 32'h0, 32'h0);
        @(negedge clk);
        chk("t4_x0_store", store, 32'd0);
        chk("t4_x0_read", {31'd0, rd_ready}, 32'd1);
        nxt();
        idle();

        // Same register on both buses.
        wr0_valid = 1'b1; wr0_rd = 5'd9; wr0_data = 32'h12345678;
        push_st(32'h1 << 9, 32'h12345678);
        nxt();
        idle();
        nxt();
        rd_valid = 1'b1; rd_rs1 = 5'd9; rd_rs2 = 5'd9;
        push_rd(32'h1 << 9, 32'h1 << 9, 32'h12345678, 32'h12345678);
        @(negedge clk);
        chk("t5_enable_a", enable_a, 32'h1 << 9);
        chk("t5_enable_b", enable_b, 32'h1 << 9);
        nxt();
        rd_valid = 1'b0;
        @(negedge clk);
        chk("t5_float_a", enable_a, 32'd0);
        chk("t5_float_b", enable_b, 32'd0);
        nxt();

        // Reset mid-operation discards the pending store and the scoreboard.
        rsv_valid = 1'b1; rsv_rd = 5'd7;
        nxt();
        rsv_valid = 1'b0;
        wr0_valid = 1'b1; wr0_rd = 5'd5; wr0_data = 32'h55;
        nxt();
        idle();
        chk("t6_busy_pre", busy, 32'h0000_0080);
        chk("t6_store_pre", store, 32'h1 << 5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_store_async", store, 32'd0);
        chk("t6_busy_async", busy, 32'd0);
        nxt();
        reset_n = 1'b1;
        wr0_valid = 1'b1; wr0_rd = 5'd1; wr0_data = 32'h11;
        wr1_valid = 1'b1; wr1_rd = 5'd2; wr1_data = 32'h22;
        push_st(32'h1 << 1, 32'h11);
        @(negedge clk);
        chk("t6_first_wr0", {31'd0, wr0_ready}, 32'd1);
        chk("t6_first_wr1", {31'd0, wr1_ready}, 32'd0);
        nxt();
        wr0_valid = 1'b0;
        push_st(32'h1 << 2, 32'h22);
        @(negedge clk);
        chk("t6_then_wr1", {31'd0, wr1_ready}, 32'd1);
        nxt();
        idle();
        repeat (3) nxt();

        chk("store_queue_drained", st_q.size(), 32'd0);
        chk("read_queue_drained", rd_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Sequences the 32-entry register bank, which is built from `register` instances on shared tri-state A/B read buses.
- Arbitrates two write-back requesters onto the single store path: wr0 (ALU) and wr1 (load unit).
- Keeps a per-register busy scoreboard for long-latency destinations.
- Gates read requests so the bank is never read while a write to the same register is outstanding.

Parameters:
- XLEN, 32, data width of registers and buses.
- NREGS, 32, number of architectural registers; register 0 is hardwired zero.
- IDX_W, 5, register index width, equal to $clog2(NREGS).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rsv_valid  in  1  reserve destination rsv_rd on issue of a long-latency op.
- rsv_rd  in  IDX_W  register index to mark busy.
- rsv_ready  out  1  reservation accepted this cycle.
- wr0_valid/wr1_valid  in  1  write-back request.
- wr0_rd/wr1_rd  in  IDX_W  destination index.
- wr0_data/wr1_data  in  XLEN  write-back value.
- wr0_ready/wr1_ready  out  1  write granted this cycle.
- rd_valid  in  1  operand read request.
- rd_rs1/rd_rs2  in  IDX_W  source indices; rs1 is driven onto bus A, rs2 onto bus B.
- rd_ready  out  1  operands valid on buses A/B this cycle.
- enable_a/enable_b  out  NREGS  one-hot per-register bus-A/B output enables.
- store  out  NREGS  one-hot per-register store strobe.
- store_data  out  XLEN  data to all register instances.
- busy  out  NREGS  scoreboard, for debug and the issue stage.

Behaviour:
- Reset (async, reset_n low): busy=0, store=0, store_data=0, pend_valid=0, last_grant=1 (wr0 wins the first conflict). enable_a, enable_b and all readies are 0 while reset_n is low.
- Write arbitration, combinational in cycle N:
  - Only one requester valid: it is granted.
  - Both valid: grant goes to the requester not in last_grant; last_grant updates on each grant.
  - The granted wrX_ready is high in cycle N.
- Write issue, registered:
  - Cycle N+1: store=onehot(rd), store_data=data, pend_valid=1, pend_rd=rd.
  - The register captures on the rising edge ending cycle N+1. Write latency is therefore 2 edges from grant.
  - store is zero in any cycle with no pending write.
- rd==0 writes: handshake is accepted (ready high), store stays all-zero, busy is unaffected.
- Scoreboard:
  - A grant clears busy[rd] at the grant edge.
  - rsv_ready = rsv_valid & !busy[rsv_rd] & !(pend_valid & pend_rd==rsv_rd). This stalls WAW.
  - An accepted reservation sets busy[rsv_rd] at the edge; rsv_rd==0 is accepted and ignored.
  - Reservation and grant on the same index in the same cycle: rsv_ready is evaluated on pre-edge busy. Because busy is still set, the reservation is refused that cycle.
  - A write to a non-busy register (ALU path) is legal.
- Read gating:
  - hazard(rs) = rs!=0 & (busy[rs] | (pend_valid & pend_rd==rs) | grant-this-cycle to rs).
  - rd_ready = rd_valid & !hazard(rs1) & !hazard(rs2).
- Bus enables:
  - enable_a=onehot(rs1) and enable_b=onehot(rs2) only when rd_ready; otherwise both are 0 and the buses float.
  - Index 0 is still enabled; the x0 instance holds 0.
  - rs1==rs2 is legal: the same instance drives both buses.
- Reset asserted mid-operation: the pending store is discarded (store forced 0 immediately) and the scoreboard is cleared. A granted-but-unissued write is lost; this is by design.

Decomposition:
- Package regfile_pkg: XLEN, NREGS, IDX_W constants; the reg_idx_t typedef; the wr_req_t struct {valid, rd, data}; an onehot(idx) function.
- Sub-module rr_arbiter2: 2-way round-robin with last_grant flop, inputs req[1:0], outputs gnt[1:0].
- Scoreboard and read gating stay inline.

Test Plan:
1. Reset, then wr0 rd=5 data=DEADBEEF. Required: wr0_ready in cycle 0; store=1<<5 and store_data=DEADBEEF in cycle 1; read rs1=5 rd_valid in cycle 1 stalls (rd_ready=0); read in cycle 2 has rd_ready=1, enable_a=1<<5, bus A=DEADBEEF.
2. wr0 rd=3 and wr1 rd=4 both valid at cycle 0. Required: wr0 granted cycle 0, wr1 granted cycle 1. Repeating with both valid grants wr1 then wr0 (alternation).
3. rsv rd=7, then read rs2=7. Required: busy[7]=1 and rd_ready=0 until wr1 rd=7 data=00000042 is granted; rd_ready=1 two cycles after the grant with bus B=00000042.
4. rsv rd=7 while busy[7]=1. Required: rsv_ready=0. Write rd=0 data=FFFFFFFF. Required: ready=1, store=0, and a read of rs1=0 returns 00000000.
5. Read rs1=9 rs2=9 with no hazard. Required: enable_a=enable_b=1<<9 and rd_ready=1 in the same cycle. rd_valid=0 gives both enables 0 (buses z).
6. Assert reset_n low for 1 cycle while store is pending and busy=0x00000080. Required: store=0 immediately, busy=0, and the next conflict grants wr0.
